// File: rtl/agc_div_pkg.sv
// Shared types and sizing helpers for the IAGC signed radix-2 divider.
package agc_div_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   function automatic int calc_steps(input int data_size, input int frac_bits);
      return data_size + frac_bits;
   endfunction

   function automatic int count_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   function automatic int signed_max(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int signed_min(input int width);
      return -(1 << (width - 1));
   endfunction

endpackage

// File: rtl/agc_divider_if.sv
// Operand/result bundle of the AGC divider with its start/busy/valid handshake.
interface agc_divider_if #(
   parameter int DATA_SIZE      = 14,
   parameter int REMAINDER_SIZE = 14
);
   logic signed [DATA_SIZE-1:0]      i_reference;
   logic signed [DATA_SIZE-1:0]      i_error;
   logic                             i_start;
   logic signed [DATA_SIZE-1:0]      o_quotient;
   logic signed [REMAINDER_SIZE-1:0] o_remainder;
   logic                             o_valid;
   logic                             o_busy;
   logic                             o_div_zero;
   logic                             o_overflow;

   modport master (
      output i_reference, i_error, i_start,
      input  o_quotient, o_remainder, o_valid, o_busy, o_div_zero, o_overflow
   );

   modport slave (
      input  i_reference, i_error, i_start,
      output o_quotient, o_remainder, o_valid, o_busy, o_div_zero, o_overflow
   );
endinterface

// File: rtl/agc_div_sat.sv
// Sign application, optional round-half-away-from-zero and saturation of the raw
// magnitudes. Rounding is built only when AGC_DIV_ROUND_EN is defined.
module agc_div_sat
   import agc_div_pkg::*;
#(
   parameter int DATA_SIZE      = 14,
   parameter int FRAC_BITS      = 8,
   parameter int REMAINDER_SIZE = 14
) (
   input  logic [DATA_SIZE+FRAC_BITS-1:0] q_mag,
   input  logic [DATA_SIZE-1:0]           rem_mag,
`ifdef AGC_DIV_ROUND_EN
   input  logic [DATA_SIZE-1:0]           div_mag,
`endif
   input  logic                           neg_quot,
   input  logic                           neg_rem,
   output logic [DATA_SIZE-1:0]           quotient,
   output logic [REMAINDER_SIZE-1:0]      remainder,
   output logic                           overflow
);
   localparam int QW = calc_steps(DATA_SIZE, FRAC_BITS) + 1;
   localparam int RW = ((DATA_SIZE > REMAINDER_SIZE) ? DATA_SIZE : REMAINDER_SIZE) + 1;
   localparam logic [QW-1:0] Q_POS = QW'(signed_max(DATA_SIZE));
   localparam logic [QW-1:0] Q_NEG = QW'(-signed_min(DATA_SIZE));
   localparam logic [RW-1:0] R_POS = RW'(signed_max(REMAINDER_SIZE));
   localparam logic [RW-1:0] R_NEG = RW'(-signed_min(REMAINDER_SIZE));

   logic [QW-1:0]             q_adj;
   logic [DATA_SIZE-1:0]      q_lo;
   logic [RW-1:0]             r_ext;
   logic [REMAINDER_SIZE-1:0] r_lo;
   logic                      q_ovf;
   logic                      r_ovf;

`ifdef AGC_DIV_ROUND_EN
   logic round_up;
   assign round_up = {rem_mag, 1'b0} >= {1'b0, div_mag};
`endif

   // Negative limits allow one extra magnitude step compared with the positive ones.
   always_comb begin
      q_adj = {1'b0, q_mag};
`ifdef AGC_DIV_ROUND_EN
      if (round_up) q_adj = q_adj + QW'(1);
`endif
      q_lo  = q_adj[DATA_SIZE-1:0];
      r_ext = RW'(rem_mag);
      r_lo  = r_ext[REMAINDER_SIZE-1:0];
      if (neg_quot) begin
         q_ovf    = q_adj > Q_NEG;
         quotient = q_ovf ? DATA_SIZE'(signed_min(DATA_SIZE)) : -q_lo;
      end else begin
         q_ovf    = q_adj > Q_POS;
         quotient = q_ovf ? DATA_SIZE'(signed_max(DATA_SIZE)) : q_lo;
      end
      if (neg_rem) begin
         r_ovf     = r_ext > R_NEG;
         remainder = r_ovf ? REMAINDER_SIZE'(signed_min(REMAINDER_SIZE)) : -r_lo;
      end else begin
         r_ovf     = r_ext > R_POS;
         remainder = r_ovf ? REMAINDER_SIZE'(signed_max(REMAINDER_SIZE)) : r_lo;
      end
      overflow = q_ovf | r_ovf;
   end

endmodule

// File: rtl/agc_divider.sv
// Signed sequential restoring divider: quotient = (error << FRAC_BITS) / reference.
// Defining AGC_DIV_ROUND_EN enables round-half-away-from-zero of the quotient.
module agc_divider
   import agc_div_pkg::*;
#(
   parameter int DATA_SIZE      = 14,
   parameter int FRAC_BITS      = 8,
   parameter int REMAINDER_SIZE = 14
) (
   input logic          i_clock,
   input logic          i_reset,
   agc_divider_if.slave bus
);
   localparam int N  = calc_steps(DATA_SIZE, FRAC_BITS);
   localparam int CW = count_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t                    state;
   logic                      start_q;
   logic [DATA_SIZE-1:0]      err_q;
   logic [DATA_SIZE-1:0]      ref_q;
   logic [N-1:0]              dividend;
   logic [DATA_SIZE-1:0]      div_mag;
   logic [DATA_SIZE-1:0]      rem_mag;
   logic [N-1:0]              q_mag;
   logic [CW-1:0]             count;
   logic                      neg_quot;
   logic                      zero;

   logic                      accept;
   logic [DATA_SIZE-1:0]      err_abs;
   logic [DATA_SIZE-1:0]      ref_abs;
   logic [DATA_SIZE:0]        rem_shift;
   logic [DATA_SIZE-1:0]      diff;
   logic                      ge;
   logic [DATA_SIZE-1:0]      sat_quot;
   logic [REMAINDER_SIZE-1:0] sat_rem;
   logic                      sat_ovf;

   assign accept    = bus.i_start & ~start_q;
   assign err_abs   = err_q[DATA_SIZE-1] ? -err_q : err_q;
   assign ref_abs   = ref_q[DATA_SIZE-1] ? -ref_q : ref_q;
   assign rem_shift = {rem_mag, dividend[count]};
   assign ge        = rem_shift >= {1'b0, div_mag};
   assign diff      = DATA_SIZE'(rem_shift - {1'b0, div_mag});

   agc_div_sat #(
      .DATA_SIZE      (DATA_SIZE),
      .FRAC_BITS      (FRAC_BITS),
      .REMAINDER_SIZE (REMAINDER_SIZE)
   ) u_sat (
      .q_mag     (q_mag),
      .rem_mag   (rem_mag),
`ifdef AGC_DIV_ROUND_EN
      .div_mag   (div_mag),
`endif
      .neg_quot  (neg_quot),
      .neg_rem   (err_q[DATA_SIZE-1]),
      .quotient  (sat_quot),
      .remainder (sat_rem),
      .overflow  (sat_ovf)
   );

   // Operands are held in err_q/ref_q for the whole division so DONE can still
   // see the dividend sign, e.g. to pick the divide-by-zero saturation limit.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state           <= IDLE;
         start_q         <= 1'b0;
         bus.o_quotient  <= '0;
         bus.o_remainder <= '0;
         bus.o_valid     <= 1'b0;
         bus.o_busy      <= 1'b0;
         bus.o_div_zero  <= 1'b0;
         bus.o_overflow  <= 1'b0;
      end else begin
         start_q     <= bus.i_start;
         bus.o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  err_q      <= bus.i_error;
                  ref_q      <= bus.i_reference;
                  bus.o_busy <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               neg_quot <= err_q[DATA_SIZE-1] ^ ref_q[DATA_SIZE-1];
               if (ref_q == '0) begin
                  zero  <= 1'b1;
                  state <= DONE;
               end else begin
                  zero     <= 1'b0;
                  dividend <= N'(err_abs) << FRAC_BITS;
                  div_mag  <= ref_abs;
                  rem_mag  <= '0;
                  q_mag    <= '0;
                  count    <= LAST;
                  state    <= CALC;
               end
            end
            CALC: begin
               rem_mag <= ge ? diff : rem_shift[DATA_SIZE-1:0];
               q_mag   <= {q_mag[N-2:0], ge};
               if (count == '0) state <= DONE;
               else             count <= count - CW'(1);
            end
            DONE: begin
               if (zero) begin
                  bus.o_quotient  <= err_q[DATA_SIZE-1] ? DATA_SIZE'(signed_min(DATA_SIZE))
                                                        : DATA_SIZE'(signed_max(DATA_SIZE));
                  bus.o_remainder <= '0;
                  bus.o_div_zero  <= 1'b1;
                  bus.o_overflow  <= 1'b1;
               end else begin
                  bus.o_quotient  <= sat_quot;
                  bus.o_remainder <= sat_rem;
                  bus.o_div_zero  <= 1'b0;
                  bus.o_overflow  <= sat_ovf;
               end
               bus.o_valid <= 1'b1;
               bus.o_busy  <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_agc_divider.sv
// Bench for agc_divider: two instances (FRAC_BITS 0 and 8) share stimulus and are
// compared against an arithmetic model; AGC_DIV_ROUND_EN selects the rounding model.
module tb_agc_divider;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic signed [13:0] err   = '0;
   logic signed [13:0] refv  = '0;

   int cyc        = 0;
   int compared   = 0;
   int mismatched = 0;
   int last_lat[2];
   int valid_count[2];

   typedef struct {
      longint q;
      longint r;
      bit     dz;
      bit     chk_ovf;
      bit     ovf;
      int     acc;
      int     lat;
   } exp_t;

   exp_t expq[2][$];

   agc_divider_if #(.DATA_SIZE(14), .REMAINDER_SIZE(14)) bus0 ();
   agc_divider_if #(.DATA_SIZE(14), .REMAINDER_SIZE(14)) bus8 ();

   assign bus0.i_start     = start;
   assign bus0.i_error     = err;
   assign bus0.i_reference = refv;
   assign bus8.i_start     = start;
   assign bus8.i_error     = err;
   assign bus8.i_reference = refv;

   agc_divider #(.DATA_SIZE(14), .FRAC_BITS(0), .REMAINDER_SIZE(14)) dut0 (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus0)
   );

   agc_divider #(.DATA_SIZE(14), .FRAC_BITS(8), .REMAINDER_SIZE(14)) dut8 (
      .i_clock (clock),
      .i_reset (reset),
      .bus     (bus8)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic int frac_of(input int k);
      return (k == 0) ? 0 : 8;
   endfunction

   function automatic longint abs_l(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   // Exact integer arithmetic: / and % truncate toward zero, % takes the dividend sign.
   function automatic exp_t model(input longint e, input longint d, input int frac, input int acc);
      exp_t   x;
      longint num, qt, rm, mag, sq;
      bit     neg;
      x.acc     = acc;
      x.dz      = 1'b0;
      x.chk_ovf = 1'b1;
      x.ovf     = 1'b0;
      if (d == 0) begin
         x.dz      = 1'b1;
         x.chk_ovf = 1'b0;
         x.q       = (e < 0) ? -8192 : 8191;
         x.r       = 0;
         x.lat     = 2;
         return x;
      end
      num = e * (longint'(1) << frac);
      qt  = num / d;
      rm  = num % d;
      mag = abs_l(qt);
      neg = (e < 0) != (d < 0);
`ifdef AGC_DIV_ROUND_EN
      if (2 * abs_l(rm) >= abs_l(d)) mag = mag + 1;
`endif
      sq = neg ? -mag : mag;
      if (sq > 8191) begin
         sq    = 8191;
         x.ovf = 1'b1;
      end else if (sq < -8192) begin
         sq    = -8192;
         x.ovf = 1'b1;
      end
      if (rm > 8191) begin
         rm    = 8191;
         x.ovf = 1'b1;
      end else if (rm < -8192) begin
         rm    = -8192;
         x.ovf = 1'b1;
      end
      x.q   = sq;
      x.r   = rm;
      x.lat = 14 + frac + 2;
      return x;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_output(input int k, input logic valid, input logic busy,
                               input longint q, input longint r, input logic dz, input logic ovf);
      exp_t x;
      bit   exp_busy;
      if (valid) begin
         if (expq[k].size() == 0) begin
            check($sformatf("dut%0d_unexpected_valid", frac_of(k)), 1, 0);
         end else begin
            x = expq[k].pop_front();
            last_lat[k] = cyc - x.acc;
            valid_count[k]++;
            check($sformatf("dut%0d_latency", frac_of(k)), cyc - x.acc, x.lat);
            check($sformatf("dut%0d_quotient", frac_of(k)), q, x.q);
            check($sformatf("dut%0d_remainder", frac_of(k)), r, x.r);
            check($sformatf("dut%0d_div_zero", frac_of(k)), dz, x.dz);
            if (x.chk_ovf) check($sformatf("dut%0d_overflow", frac_of(k)), ovf, x.ovf);
         end
      end else if (expq[k].size() != 0 && cyc - expq[k][0].acc > expq[k][0].lat) begin
         check($sformatf("dut%0d_valid_timeout", frac_of(k)), 0, 1);
         x = expq[k].pop_front();
      end
      exp_busy = (expq[k].size() != 0) && (cyc >= expq[k][0].acc);
      check($sformatf("dut%0d_busy", frac_of(k)), busy, exp_busy);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         check_output(0, bus0.o_valid, bus0.o_busy, bus0.o_quotient, bus0.o_remainder,
                      bus0.o_div_zero, bus0.o_overflow);
         check_output(1, bus8.o_valid, bus8.o_busy, bus8.o_quotient, bus8.o_remainder,
                      bus8.o_div_zero, bus8.o_overflow);
      end
   end

   task automatic apply_stimulus(input longint e, input longint d, input bit accepted, input int hold);
      @(posedge clock);
      #1;
      err   = 14'(e);
      refv  = 14'(d);
      start = 1'b1;
      if (accepted) begin
         for (int k = 0; k < 2; k++) expq[k].push_back(model(e, d, frac_of(k), cyc + 1));
      end
      repeat (hold) @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && (expq[0].size() + expq[1].size()) != 0; i++) @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(posedge clock);
      #1;
      reset = 1'b1;
      start = 1'b0;
      expq[0].delete();
      expq[1].delete();
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int  v0;
      longint e, d;

      repeat (5) @(posedge clock);
      @(negedge clock);
      check("rst_q0", bus0.o_quotient, 0);
      check("rst_r0", bus0.o_remainder, 0);
      check("rst_valid0", bus0.o_valid, 0);
      check("rst_busy0", bus0.o_busy, 0);
      check("rst_dz0", bus0.o_div_zero, 0);
      check("rst_ovf0", bus0.o_overflow, 0);
      check("rst_q8", bus8.o_quotient, 0);
      check("rst_r8", bus8.o_remainder, 0);
      check("rst_valid8", bus8.o_valid, 0);
      check("rst_busy8", bus8.o_busy, 0);
      check("rst_dz8", bus8.o_div_zero, 0);
      check("rst_ovf8", bus8.o_overflow, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      apply_stimulus(100, 7, 1'b1, 1);
      wait_done();
      check("lit_lat_100_7_f0", last_lat[0], 16);
      check("lit_q_100_7_f0", bus0.o_quotient, 14);
      check("lit_r_100_7_f0", bus0.o_remainder, 2);
      check("lit_ovf_100_7_f0", bus0.o_overflow, 0);

      apply_stimulus(-100, 7, 1'b1, 1);
      wait_done();
      check("lit_q_m100_7_f0", bus0.o_quotient, -14);
      check("lit_r_m100_7_f0", bus0.o_remainder, -2);

      apply_stimulus(1, 3, 1'b1, 1);
      wait_done();
      check("lit_lat_1_3_f8", last_lat[1], 24);
      check("lit_q_1_3_f8", bus8.o_quotient, 85);
      check("lit_r_1_3_f8", bus8.o_remainder, 1);

      apply_stimulus(2, 3, 1'b1, 1);
      wait_done();
`ifdef AGC_DIV_ROUND_EN
      check("lit_q_2_3_f8", bus8.o_quotient, 171);
`else
      check("lit_q_2_3_f8", bus8.o_quotient, 170);
`endif

      apply_stimulus(-4104, 0, 1'b1, 1);
      wait_done();
      check("lit_lat_divzero_f8", last_lat[1], 2);
      check("lit_dz_divzero_f8", bus8.o_div_zero, 1);
      check("lit_q_divzero_f8", bus8.o_quotient, -8192);

      apply_stimulus(8191, 1, 1'b1, 1);
      wait_done();
      check("lit_q_sat_f8", bus8.o_quotient, 8191);
      check("lit_ovf_sat_f8", bus8.o_overflow, 1);

      v0 = valid_count[1];
      apply_stimulus(300, -11, 1'b1, 10);
      wait_done();
      check("lit_held_start_one_result", valid_count[1] - v0, 1);

      apply_stimulus(50, 9, 1'b1, 1);
      repeat (4) @(posedge clock);
      apply_stimulus(-77, 5, 1'b0, 1);
      wait_done();
      check("lit_q_busy_ignore_f8", bus8.o_quotient, 1422);

      v0 = valid_count[1];
      apply_stimulus(1000, 13, 1'b1, 1);
      repeat (11) @(posedge clock);
      do_reset(1);
      @(negedge clock);
      check("lit_abort_busy0", bus0.o_busy, 0);
      check("lit_abort_busy8", bus8.o_busy, 0);
      repeat (30) @(posedge clock);
      check("lit_abort_no_valid", valid_count[1] - v0, 0);

      apply_stimulus(-300, 13, 1'b1, 1);
      wait_done();
      check("lit_q_after_abort_f0", bus0.o_quotient, -23);
      check("lit_r_after_abort_f0", bus0.o_remainder, -1);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 7))
            0:       e = -8192;
            1:       e = 8191;
            default: e = longint'($urandom_range(0, 16383)) - 8192;
         endcase
         case ($urandom_range(0, 7))
            0:       d = 0;
            1:       d = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(1, 4))
                                                     : -longint'($urandom_range(1, 4));
            2:       d = -8192;
            default: d = longint'($urandom_range(0, 16383)) - 8192;
         endcase
         apply_stimulus(e, d, 1'b1, 1);
         wait_done();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/agc_divider.md
Name: agc_divider

Overview:
- Parametrised, signed, sequential radix-2 divider for the IAGC loop.
- Computes quotient = (i_error · 2^FRAC_BITS) / i_reference, plus the remainder.
- Adds fractional gain bits, a divide-by-zero flag, saturation on overflow, and a start/busy/valid handshake.
- Sits between the error computation and the gain-update stage; one result per start request.

Parameters:
- DATA_SIZE, 14, width of the signed two's-complement operands and of o_quotient.
- FRAC_BITS, 8, fractional bits appended to the dividend. Range 0..DATA_SIZE.
- REMAINDER_SIZE, 14, width of the signed o_remainder. Must be ≥ 2.

Ports:
- i_clock  in  1  system clock; all state changes on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_reference  in  DATA_SIZE  signed divisor. Sampled on the accept cycle.
- i_error  in  DATA_SIZE  signed dividend. Sampled on the accept cycle.
- i_start  in  1  request. Rising-edge detected.
- o_quotient  out  DATA_SIZE  signed quotient in Q(DATA_SIZE-FRAC_BITS).FRAC_BITS format.
- o_remainder  out  REMAINDER_SIZE  signed remainder; sign follows the dividend.
- o_valid  out  1  one-cycle pulse when the outputs are updated.
- o_busy  out  1  high while a division is in progress.
- o_div_zero  out  1  sticky per result: the divisor was 0.
- o_overflow  out  1  sticky per result: the quotient was saturated.

Behaviour:
- Reset (synchronous, active-high; takes effect in any state, including mid-division):
  - state returns to IDLE; in-flight work is discarded.
  - o_quotient, o_remainder, o_valid, o_busy, o_div_zero and o_overflow are all 0.
  - the start-edge register is cleared to 0.
- Start detection: accept = i_start AND NOT start_q (start_q is i_start registered). A level held for many cycles yields exactly one request.
- A start edge is ignored unless state is IDLE. Any edge arriving while busy or during DONE is dropped, not queued.
- States:
  - IDLE → LOAD on accept. Operands are registered on the accept edge.
  - LOAD:
    - if the divisor is 0, go to DONE. o_div_zero=1; quotient saturates to +max (dividend ≥ 0) or −max−1 (dividend < 0); remainder = 0.
    - otherwise convert both operands to magnitude, record sign_q = sign(err) XOR sign(ref), and go to CALC.
  - CALC: one restoring step per cycle, N = DATA_SIZE + FRAC_BITS cycles. A counter runs from N−1 down to 0; at 0 go to DONE.
  - DONE: apply signs, saturate, register the outputs, pulse o_valid for 1 cycle, return to IDLE.
- o_busy = 1 in LOAD, CALC and DONE.
- Latency, with the accept edge at cycle 0:
  - normal division: o_valid at cycle N+2 (cycle 24 with the defaults).
  - divide by zero: o_valid at cycle 2.
- Arithmetic:
  - magnitude dividend = |err| << FRAC_BITS, width N+1. −2^(DATA_SIZE−1) converts correctly.
  - the raw quotient magnitude is N+1 bits and is truncated toward zero.
  - if the signed result is outside [−2^(DATA_SIZE−1), 2^(DATA_SIZE−1)−1], clamp to the nearest limit and set o_overflow.
  - remainder = sign(err)·rem_mag, clamped to the REMAINDER_SIZE signed range; clamping also sets o_overflow.
- Outputs hold their last values between results. o_div_zero and o_overflow are recomputed with every result.

Optional Feature:
- Macro: AGC_DIV_ROUND_EN.
- Defined:
  - after CALC, if 2·rem_mag ≥ |ref|, increment the quotient magnitude by 1 (round half away from zero).
  - saturation is applied after rounding.
  - o_remainder still reports the pre-rounding remainder.
  - latency is unchanged.
- Undefined: truncation toward zero only; none of the rounding logic is present.

Decomposition:
- Package agc_div_pkg:
  - state enum (IDLE, LOAD, CALC, DONE), 2-bit encoding.
  - localparam helpers for N and the counter width, $clog2(N).
  - functions for the signed max/min of a given width.
- One sub-module, agc_div_sat: combinational sign application, optional rounding, and saturation of quotient/remainder with the overflow flag. It is instantiated in the DONE path.

Test Plan:
- Reset, FRAC_BITS=0: hold i_reset 5 cycles → all outputs 0.
- Divisions with FRAC_BITS=0:
  - err=100, ref=7, start pulse → o_valid at cycle 16, q=14, r=2, o_overflow=0.
  - err=−100, ref=7 → q=−14, r=−2.
- Fractional, FRAC_BITS=8, err=1, ref=3 → q=85 (0x055), r=1.
- Rounding:
  - FRAC_BITS=8, err=2, ref=3 → q=170 without AGC_DIV_ROUND_EN, q=171 with it.
  - FRAC_BITS=8, err=1, ref=3 → q=85 in both builds.
- Boundaries, FRAC_BITS=8:
  - err=−4104, ref=0 → o_valid at cycle 2, o_div_zero=1, q=−8192.
  - err=8191, ref=1 → q=8191, o_overflow=1.
- Handshake and reset abort:
  - hold i_start high 10 cycles → exactly one o_valid.
  - start edge while o_busy → ignored.
  - i_reset asserted at cycle 10 of CALC → o_busy=0 next cycle and no o_valid.
  - next start edge → correct result.
